calc_port_drv: RTL
==================

CALC_PORT_DRV -- requirements
Module: calc_port_drv

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of independent calculator ports driven.
REQ-002 Parameter DATA_W, default 32, operand/result width.
REQ-003 Parameter RST_HOLD, default 7, cycles DUT reset stays high after block reset falls.
REQ-004 Parameter TIMEOUT, default 64, cycles before an outstanding tag is declared lost.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 req_valid/req_ready  in/out  NUM_PORTS  per-port request handshake.
REQ-008 req_cmd  in  NUM_PORTS x 4  opcode (0 nop, 1 add, 2 sub, 5 shl, 6 shr).
REQ-009 req_d1, req_d2  in  NUM_PORTS x DATA_W  first/second operand.
REQ-010 dut_reset  out  1  reset to DUT.
REQ-011 dut_cmd, dut_tag, dut_data  out  NUM_PORTS x 4 / 2 / DATA_W  DUT request bus.
REQ-012 dut_resp, dut_rtag, dut_rdata  in  NUM_PORTS x 2 / 2 / DATA_W  DUT response bus; resp 0 = none.
REQ-013 cpl_valid, cpl_timeout  out  NUM_PORTS each  completion pulse, timeout flag.
REQ-014 cpl_resp, cpl_tag, cpl_data  out  NUM_PORTS x 2 / 2 / DATA_W  completion payload.

Function
REQ-015 dut_reset SHALL be high while reset is high and exactly RST_HOLD cycles after; req_ready SHALL be 0 while dut_reset is high.
REQ-016 Per-port FSM: IDLE -> CMD on accept (req_valid & req_ready); CMD -> D2; D2 -> IDLE; one cycle each, no stalls.
REQ-017 req_ready[p] SHALL be 1 only in IDLE with at least one of 4 tags free per registered busy map.
REQ-018 Accept SHALL allocate the lowest-numbered free tag and set its busy bit.
REQ-019 CMD cycle: dut_cmd=opcode, dut_data=d1, dut_tag=tag; D2 cycle: dut_cmd=0, dut_data=d2; IDLE: all dut_* = 0.
REQ-020 dut_resp[p]!=0 SHALL give cpl_valid[p]=1 next cycle for one cycle with resp, rtag, rdata copied and cpl_timeout=0; busy bit of rtag cleared same edge.
REQ-021 Response on non-busy tag SHALL still complete (cpl_resp as received) but not alter busy map.
REQ-022 Tag freed by response SHALL be reallocatable no earlier than the following cycle.
REQ-023 Completions have no backpressure; ports fully independent.
REQ-024 Max 4 outstanding per port; 5th request held off (ready=0) until a tag frees.

Reset
REQ-025 On reset: FSMs IDLE, busy maps and counters cleared, all dut_* except dut_reset = 0, req_ready=0, cpl_* = 0.
REQ-026 Reset mid-transaction SHALL drop all outstanding tags without emitting completions.

Configuration
REQ-027 Macro CALC_PORT_DRV_TIMEOUT_EN: when defined, a per-tag counter increments while busy; at TIMEOUT it emits cpl_valid=1, cpl_timeout=1, cpl_resp=0, cpl_data=0, cpl_tag=tag and frees the tag.
REQ-028 Response and timeout for the same port in one cycle: response completes, timeout deferred one cycle (re-checked); lowest expired tag first.
REQ-029 Macro undefined: no counters; cpl_timeout tied 0; tags free only on response.

Structure
REQ-030 Package calc_drv_pkg SHALL hold opcode enum, response enum, FSM state enum, TAG_W=2, NUM_TAGS=4.
REQ-031 Sub-module calc_port_chan SHALL implement one port (FSM, tag map, timers), instantiated NUM_PORTS times by generate.

Verification
REQ-032 Reset release -> dut_reset high exactly 7 cycles more, req_ready 0 throughout, then 1.
REQ-033 Port0 add 5+3 -> dut_cmd=1,d1=5,tag=0 then d2=3; DUT resp 1,data 8,tag 0 -> cpl_valid next cycle, data 8.
REQ-034 Five back-to-back requests on port2 without responses -> tags 0..3 issued, 5th waits; response tag1 -> 5th gets tag 1 cycle after.
REQ-035 TIMEOUT_EN, TIMEOUT=64, no response -> cpl_timeout=1 tag 0 at 64 cycles after issue; undefined -> never.
REQ-036 All 4 ports accept same cycle, responses same cycle -> four independent correct completions.
REQ-037 reset asserted with 3 tags outstanding -> no completions, busy map empty after.

Source files
------------

// File: rtl/calc_drv_pkg.sv
// Shared types and constants for the calculator port driver.
package calc_drv_pkg;

  localparam int TAG_W    = 2;
  localparam int NUM_TAGS = 4;
  localparam int CMD_W    = 4;
  localparam int RESP_W   = 2;

  typedef enum logic [CMD_W-1:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6
  } opcode_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2,
    RESP_RSVD = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_D2   = 2'd2
  } state_e;

  // Index of the lowest clear bit; callers guarantee at least one is clear.
  function automatic logic [TAG_W-1:0] lowest_free(input logic [NUM_TAGS-1:0] busy);
    lowest_free = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) lowest_free = TAG_W'(i);
    end
  endfunction

endpackage

// File: rtl/calc_port_chan.sv
// One calculator port: request FSM, tag busy map, completion register and,
// when CALC_PORT_DRV_TIMEOUT_EN is defined, per-tag lost-response timers.
module calc_port_chan
  import calc_drv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic [DATA_W-1:0] req_d1,
  input  logic [DATA_W-1:0] req_d2,
  output logic [CMD_W-1:0]  dut_cmd,
  output logic [TAG_W-1:0]  dut_tag,
  output logic [DATA_W-1:0] dut_data,
  input  logic [RESP_W-1:0] dut_resp,
  input  logic [TAG_W-1:0]  dut_rtag,
  input  logic [DATA_W-1:0] dut_rdata,
  output logic              cpl_valid,
  output logic              cpl_timeout,
  output logic [RESP_W-1:0] cpl_resp,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [DATA_W-1:0] cpl_data
);

  state_e              state_q, state_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]    tag_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   d1_q, d2_q;
  logic [TAG_W-1:0]    alloc;
  logic                accept;
  logic                resp_hit;
  logic                to_fire;
  logic [TAG_W-1:0]    to_tag;

  assign req_ready = (state_q == ST_IDLE) && !hold && (busy_q != '1);
  assign accept    = req_valid && req_ready;
  assign alloc     = lowest_free(busy_q);
  assign resp_hit  = (dut_resp != RESP_NONE);

`ifdef CALC_PORT_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [NUM_TAGS-1:0][CNT_W-1:0] age_q;
  logic [NUM_TAGS-1:0]            expired;

  always_comb begin
    for (int t = 0; t < NUM_TAGS; t++) expired[t] = busy_q[t] && (age_q[t] >= LIMIT);
  end

  // A response owns the completion slot; an expired tag simply waits a cycle.
  assign to_fire = (|expired) && !resp_hit;
  assign to_tag  = lowest_free(~expired);

  // Per-tag age: zeroed on allocation, counts while busy, saturates at LIMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_q <= '0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (accept && (alloc == TAG_W'(t)))   age_q[t] <= '0;
        else if (busy_q[t] && age_q[t] < LIMIT) age_q[t] <= age_q[t] + CNT_W'(1);
      end
    end
  end
`else
  assign to_fire = 1'b0;
  assign to_tag  = '0;
`endif

  // Next state, busy map update and request-bus drive.
  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    dut_cmd  = '0;
    dut_tag  = '0;
    dut_data = '0;
    busy_d   = busy_q;
    // Clearing a tag that is not busy is a no-op, so stray responses leave the map alone.
    if (resp_hit)     busy_d[dut_rtag] = 1'b0;
    else if (to_fire) busy_d[to_tag]   = 1'b0;
    if (accept)       busy_d[alloc]    = 1'b1;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CMD;
      ST_CMD: begin
        state_d  = ST_D2;
        dut_cmd  = cmd_q;
        dut_tag  = tag_q;
        dut_data = d1_q;
      end
      ST_D2: begin
        state_d  = ST_IDLE;
        dut_tag  = tag_q;
        dut_data = d2_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and busy map.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // Request payload capture.
  // NOTE: payload flops have no reset; they only reach the bus outside IDLE, after a fresh capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q <= alloc;
      cmd_q <= req_cmd;
      d1_q  <= req_d1;
      d2_q  <= req_d2;
    end
  end

  // One-cycle completion pulse: responses first, then a deferred timeout.
  always_ff @(posedge clk) begin
    if (reset || !(resp_hit || to_fire)) begin
      cpl_valid   <= 1'b0;
      cpl_timeout <= 1'b0;
      cpl_resp    <= '0;
      cpl_tag     <= '0;
      cpl_data    <= '0;
    end else if (resp_hit) begin
      cpl_valid   <= 1'b1;
      cpl_timeout <= 1'b0;
      cpl_resp    <= dut_resp;
      cpl_tag     <= dut_rtag;
      cpl_data    <= dut_rdata;
    end else begin
      cpl_valid   <= 1'b1;
      cpl_timeout <= 1'b1;
      cpl_resp    <= '0;
      cpl_tag     <= to_tag;
      cpl_data    <= '0;
    end
  end

endmodule

// File: rtl/calc_port_drv.sv
// Multi-port calculator driver: DUT reset stretcher plus NUM_PORTS independent
// port channels. Optional feature macro: CALC_PORT_DRV_TIMEOUT_EN.
module calc_port_drv
  import calc_drv_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int RST_HOLD  = 7,
  parameter int TIMEOUT   = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0]               req_valid,
  output logic [NUM_PORTS-1:0]               req_ready,
  input  logic [NUM_PORTS-1:0][CMD_W-1:0]    req_cmd,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_d1,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   req_d2,
  output logic                               dut_reset,
  output logic [NUM_PORTS-1:0][CMD_W-1:0]    dut_cmd,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]    dut_tag,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   dut_data,
  input  logic [NUM_PORTS-1:0][RESP_W-1:0]   dut_resp,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0]    dut_rtag,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   dut_rdata,
  output logic [NUM_PORTS-1:0]               cpl_valid,
  output logic [NUM_PORTS-1:0]               cpl_timeout,
  output logic [NUM_PORTS-1:0][RESP_W-1:0]   cpl_resp,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]    cpl_tag,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   cpl_data
);

  localparam int HOLD_W = $clog2(RST_HOLD + 2);

  logic [HOLD_W-1:0] hold_cnt;

  // Reload the stretch counter during reset, then count it down to zero.
  always_ff @(posedge clk) begin
    if (reset)                hold_cnt <= HOLD_W'(RST_HOLD);
    else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  assign dut_reset = reset || (hold_cnt != '0);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_port_chan #(
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .hold        (dut_reset),
      .req_valid   (req_valid[p]),
      .req_ready   (req_ready[p]),
      .req_cmd     (req_cmd[p]),
      .req_d1      (req_d1[p]),
      .req_d2      (req_d2[p]),
      .dut_cmd     (dut_cmd[p]),
      .dut_tag     (dut_tag[p]),
      .dut_data    (dut_data[p]),
      .dut_resp    (dut_resp[p]),
      .dut_rtag    (dut_rtag[p]),
      .dut_rdata   (dut_rdata[p]),
      .cpl_valid   (cpl_valid[p]),
      .cpl_timeout (cpl_timeout[p]),
      .cpl_resp    (cpl_resp[p]),
      .cpl_tag     (cpl_tag[p]),
      .cpl_data    (cpl_data[p])
    );
  end

endmodule
